// File: rtl/block_exp_detect_pkg.sv
// Shared block-floating-point definitions: count type and redundant-sign-bit function.
package fft_bfp_pkg;

  localparam int CNT_W              = 5;
  localparam int DEFAULT_I_WIDTH    = 23;
  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  // Counts bits below bit w-1 that match it; bits of x above w-1 are ignored.
  function automatic cnt_t lzs(input logic [31:0] x, input int w);
    cnt_t cnt;
    logic msb;
    logic run;
    cnt = '0;
    run = 1'b1;
    msb = x[w-1];
    for (int i = 30; i >= 0; i--) begin
      if (run && (i <= w - 2)) begin
        if (x[i] == msb) cnt = cnt + cnt_t'(1);
        else             run = 1'b0;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/block_exp_detect_lzs_min_tree.sv
// Per-lane clamped redundant-sign-bit count, and minimum over a registered copy of those counts.
module lzs_min_tree
  import fft_bfp_pkg::*;
#(
  parameter int N       = 32,
  parameter int W       = 23,
  parameter int MAX_CNT = 22
) (
  input  logic signed [W-1:0] samples [0:N-1],
  output cnt_t                cnt     [0:N-1],
  input  cnt_t                cnt_q   [0:N-1],
  output cnt_t                min_cnt
);

  localparam cnt_t MAX_C = cnt_t'(MAX_CNT);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt[i] = lzs(32'(samples[i]), W);
      if (cnt[i] > MAX_C) cnt[i] = MAX_C;
    end
  end

  always_comb begin
    min_cnt = MAX_C;
    for (int i = 0; i < N; i++) begin
      if (cnt_q[i] < min_cnt) min_cnt = cnt_q[i];
    end
  end

endmodule

// File: rtl/block_exp_detect.sv
// Frame-wide minimum redundant-sign-bit detector feeding the FFT output normaliser.
// Optional macro BEXP_GUARD_BIT_EN reserves one guard bit in the reported count.
module block_exp_detect
  import fft_bfp_pkg::*;
#(
  parameter int I_WIDTH    = DEFAULT_I_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAX_CNT    = 22
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      din_valid,
  input  logic                      din_last,
  input  logic signed [I_WIDTH-1:0] din_re [0:DATA_WIDTH-1],
  input  logic signed [I_WIDTH-1:0] din_im [0:DATA_WIDTH-1],
  output logic [CNT_W-1:0]          min_cnt,
  output logic                      min_cnt_valid,
  output logic                      frame_busy
);

  localparam int   N     = 2 * DATA_WIDTH;
  localparam cnt_t MAX_C = cnt_t'(MAX_CNT);

  logic signed [I_WIDTH-1:0] samples [0:N-1];
  cnt_t lzs_d [0:N-1];
  cnt_t lzs_q [0:N-1];
  cnt_t beat_min_d, beat_min_q, run_min, frame_min, out_cnt;
  logic s1_valid, s1_last, s2_valid, s2_last;

  always_comb begin
    for (int i = 0; i < DATA_WIDTH; i++) begin
      samples[i]              = din_re[i];
      samples[i + DATA_WIDTH] = din_im[i];
    end
  end

  lzs_min_tree #(
    .N       (N),
    .W       (I_WIDTH),
    .MAX_CNT (MAX_CNT)
  ) u_tree (
    .samples (samples),
    .cnt     (lzs_d),
    .cnt_q   (lzs_q),
    .min_cnt (beat_min_d)
  );

  always_comb begin
    frame_min = (beat_min_q < run_min) ? beat_min_q : run_min;
`ifdef BEXP_GUARD_BIT_EN
    out_cnt = (frame_min == '0) ? '0 : frame_min - cnt_t'(1);
`else
    out_cnt = frame_min;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) lzs_q[i] <= '0;
      s1_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s2_valid   <= 1'b0;
      s2_last    <= 1'b0;
      beat_min_q <= '0;
    end else begin
      s1_valid <= din_valid;
      s1_last  <= din_valid & din_last;
      if (din_valid) begin
        for (int i = 0; i < N; i++) lzs_q[i] <= lzs_d[i];
      end
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      if (s1_valid) beat_min_q <= beat_min_d;
    end
  end

  // Reload and result share the S3 cycle, so a following frame never sees the old minimum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_min       <= MAX_C;
      min_cnt       <= '0;
      min_cnt_valid <= 1'b0;
    end else begin
      min_cnt_valid <= 1'b0;
      if (s2_last) begin
        min_cnt       <= out_cnt;
        min_cnt_valid <= 1'b1;
        run_min       <= MAX_C;
      end else if (s2_valid) begin
        run_min <= frame_min;
      end
    end
  end

  // Beats already in S1 or on the input when the last retires belong to the next frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_busy <= 1'b0;
    end else if (din_valid) begin
      frame_busy <= 1'b1;
    end else if (s2_last && !s1_valid) begin
      frame_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_block_exp_detect.sv
// Directed bench for block_exp_detect; honours BEXP_GUARD_BIT_EN when computing expected counts.
module tb_block_exp_detect;

  localparam int IW = 23;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic din_valid, din_last;
  logic signed [IW-1:0] din_re [0:DW-1];
  logic signed [IW-1:0] din_im [0:DW-1];
  logic [4:0] min_cnt, min_cnt10;
  logic       min_cnt_valid, min_cnt_valid10;
  logic       frame_busy, frame_busy10;

  block_exp_detect u_dut (
    .clk           (clk),
    .rstn          (rstn),
    .din_valid     (din_valid),
    .din_last      (din_last),
    .din_re        (din_re),
    .din_im        (din_im),
    .min_cnt       (min_cnt),
    .min_cnt_valid (min_cnt_valid),
    .frame_busy    (frame_busy)
  );

  block_exp_detect #(.MAX_CNT(10)) u_dut10 (
    .clk           (clk),
    .rstn          (rstn),
    .din_valid     (din_valid),
    .din_last      (din_last),
    .din_re        (din_re),
    .din_im        (din_im),
    .min_cnt       (min_cnt10),
    .min_cnt_valid (min_cnt_valid10),
    .frame_busy    (frame_busy10)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int val;
    int busy;
  } pulse_t;

  pulse_t q[$];
  pulse_t q10[$];

  always @(negedge clk) begin
    if (min_cnt_valid)   q.push_back('{cyc, int'(min_cnt), int'(frame_busy)});
    if (min_cnt_valid10) q10.push_back('{cyc, int'(min_cnt10), int'(frame_busy10)});
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int g(input int m);
`ifdef BEXP_GUARD_BIT_EN
    return (m > 0) ? m - 1 : 0;
`else
    return m;
`endif
  endfunction

  task automatic clear_lanes();
    for (int i = 0; i < DW; i++) begin
      din_re[i] = '0;
      din_im[i] = '0;
    end
  endtask

  // Next cycle's beat; caller then sets lanes in the same time step.
  task automatic drive(input logic v, input logic l, output int dc);
    @(posedge clk);
    #1;
    din_valid = v;
    din_last  = l;
    clear_lanes();
    dc = cyc;
  endtask

  task automatic idle(input int n);
    int d;
    repeat (n) drive(1'b0, 1'b0, d);
  endtask

  task automatic expect_one(input string tag, input int dc, input int val, input int busy);
    check({tag, "_npulse"}, q.size(), 1);
    if (q.size() > 0) begin
      check({tag, "_cyc"},  q[0].cyc,  dc + 3);
      check({tag, "_val"},  q[0].val,  val);
      check({tag, "_busy"}, q[0].busy, busy);
    end
    q.delete();
    q10.delete();
  endtask

  int d, dc, dca, dcb;

  initial begin
    din_valid = 1'b0;
    din_last  = 1'b0;
    clear_lanes();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    check("rst_min_cnt", int'(min_cnt), 0);
    check("rst_valid",   int'(min_cnt_valid), 0);
    check("rst_busy",    int'(frame_busy), 0);

    // single-beat frame, lzs 13
    drive(1'b1, 1'b1, dc);
    din_re[3] = 23'h000100;
    idle(1);
    check("t1_busy_set", int'(frame_busy), 1);
    idle(6);
    expect_one("t1", dc, g(13), 0);
    check("t1_hold", int'(min_cnt), g(13));

    // 4-beat frame, beat minima 20, 9, 15, 22
    drive(1'b1, 1'b0, d);  din_im[0]  = 23'h000002;
    drive(1'b1, 1'b0, d);  din_im[7]  = 23'h001000;
    drive(1'b1, 1'b0, d);  din_re[15] = 23'h000040;
    drive(1'b1, 1'b1, dc);
    idle(6);
    expect_one("t2", dc, g(9), 0);

    // back-to-back frames: A min 5 on its last beat, B min 18 on its first beat
    drive(1'b1, 1'b0, d);
    drive(1'b1, 1'b0, d);
    drive(1'b1, 1'b0, d);
    drive(1'b1, 1'b1, dca); din_re[0]  = 23'h010000;
    drive(1'b1, 1'b0, d);   din_im[15] = 23'h000008;
    drive(1'b1, 1'b0, d);
    drive(1'b1, 1'b0, d);
    drive(1'b1, 1'b1, dcb);
    idle(6);
    check("t3_npulse", q.size(), 2);
    if (q.size() >= 2) begin
      check("t3a_cyc",  q[0].cyc,  dca + 3);
      check("t3a_val",  q[0].val,  g(5));
      check("t3a_busy", q[0].busy, 1);
      check("t3b_gap",  q[1].cyc - q[0].cyc, 4);
      check("t3b_val",  q[1].val,  g(18));
      check("t3b_busy", q[1].busy, 0);
    end
    q.delete();
    q10.delete();

    // extremes: most negative everywhere
    drive(1'b1, 1'b1, dc);
    for (int i = 0; i < DW; i++) begin
      din_re[i] = 23'h400000;
      din_im[i] = 23'h400000;
    end
    idle(6);
    expect_one("t4_neg", dc, g(0), 0);

    // all -1 on re, zero on im
    drive(1'b1, 1'b1, dc);
    for (int i = 0; i < DW; i++) din_re[i] = '1;
    idle(6);
    expect_one("t4_m1", dc, g(22), 0);

    // zero data, also checked on the MAX_CNT=10 instance
    drive(1'b1, 1'b1, dc);
    idle(6);
    check("t4_max10_npulse", q10.size(), 1);
    if (q10.size() > 0) begin
      check("t4_max10_cyc", q10[0].cyc, dc + 3);
      check("t4_max10_val", q10[0].val, g(10));
    end
    expect_one("t4_zero", dc, g(22), 0);

    // bubbles and a last without valid
    drive(1'b1, 1'b0, d);  din_re[5] = 23'h000002;
    drive(1'b0, 1'b0, d);
    drive(1'b0, 1'b1, d);
    drive(1'b0, 1'b0, d);
    drive(1'b1, 1'b1, dc); din_im[2] = 23'h000040;
    idle(6);
    expect_one("t5", dc, g(15), 0);

    // reset on beat 2 of 4, then a fresh 1-beat frame with min 7
    drive(1'b1, 1'b0, d);  din_re[1] = 23'h040000;
    drive(1'b1, 1'b0, d);  din_re[2] = 23'h040000;
    #2;
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(6);
    check("t6_nopulse", q.size(), 0);
    check("t6_busy_rst", int'(frame_busy), 0);
    check("t6_cnt_rst",  int'(min_cnt), 0);
    q.delete();
    q10.delete();
    drive(1'b1, 1'b1, dc); din_re[9] = 23'h004000;
    idle(6);
    expect_one("t6", dc, g(7), 0);
    check("t6_busy_end", int'(frame_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
